// File: rtl/transposed_fir_hls_div_30s_14ns_16_seq.sv
// Iterative restoring divider: signed 30-bit dividend / unsigned 14-bit divisor -> saturated 16-bit quotient.
// Optional round-half-away-from-zero quotient when DIV_ROUND_NEAREST_EN is defined.
module transposed_fir_hls_div_30s_14ns_16_seq #(
  parameter int unsigned DIVIDEND_W = 30,
  parameter int unsigned DIVISOR_W  = 14,
  parameter int unsigned QUOT_W     = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W:0]    remainder,
  output logic                  ovf,
  output logic                  dbz
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
  localparam int unsigned MAG_W = DIVIDEND_W + 1;
  localparam int unsigned REM_W = DIVISOR_W + 1;
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DIVIDEND_W - 1);
  localparam logic [MAG_W-1:0]  POS_MAX = MAG_W'(2 ** (QUOT_W - 1) - 1);
  localparam logic [MAG_W-1:0]  NEG_MAX = MAG_W'(2 ** (QUOT_W - 1));
  localparam logic [QUOT_W-1:0] POS_Q   = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0] NEG_Q   = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_neg;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [DIVISOR_W-1:0]  r_div;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  logic [DIVISOR_W:0]    w_trial;
  logic                  w_qbit;
  logic [DIVISOR_W-1:0]  w_rem_nxt;
  logic [DIVIDEND_W-1:0] w_q_nxt;

  assign w_trial   = {r_rem, r_q[DIVIDEND_W-1]};
  assign w_qbit    = (w_trial >= {1'b0, r_div});
  assign w_rem_nxt = DIVISOR_W'(w_qbit ? (w_trial - {1'b0, r_div}) : w_trial);
  assign w_q_nxt   = {r_q[DIVIDEND_W-2:0], w_qbit};

  // Result formatting on the final step (optional rounding, sign, saturation)
  logic [MAG_W-1:0]  w_mag;
  logic              w_dbz;
  logic              w_clamp;
  logic [QUOT_W-1:0] w_quot;
  logic [REM_W-1:0]  w_rem_out;

`ifdef DIV_ROUND_NEAREST_EN
  assign w_mag = MAG_W'(w_q_nxt) + MAG_W'({w_rem_nxt, 1'b0} >= {1'b0, r_div});
`else
  assign w_mag = MAG_W'(w_q_nxt);
`endif

  assign w_dbz     = (r_div == '0);
  assign w_clamp   = w_dbz | (r_neg ? (w_mag > NEG_MAX) : (w_mag > POS_MAX));
  assign w_quot    = w_clamp ? (r_neg ? NEG_Q : POS_Q)
                             : (r_neg ? QUOT_W'(MAG_W'(0) - w_mag) : QUOT_W'(w_mag));
  assign w_rem_out = w_dbz ? '0
                   : (r_neg ? REM_W'(REM_W'(0) - {1'b0, w_rem_nxt}) : {1'b0, w_rem_nxt});

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_q       <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_neg    <= dividend[DIVIDEND_W-1];
            r_q      <= dividend[DIVIDEND_W-1] ? DIVIDEND_W'(0) - dividend : dividend;
            r_rem    <= '0;
            r_div    <= divisor;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_q   <= w_q_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            quotient  <= w_quot;
            remainder <= w_rem_out;
            ovf       <= w_clamp;
            dbz       <= w_dbz;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transposed_fir_hls_div_30s_14ns_16_seq.sv
// Self-checking bench for the sequential 30s/14ns divider against an integer-arithmetic reference model.
module tb_transposed_fir_hls_div_30s_14ns_16_seq;

  typedef struct {
    longint q;
    longint r;
    logic   ovf;
    logic   dbz;
  } exp_t;

  logic        clk;
  logic        ap_rst;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] dividend;
  logic [13:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [14:0] remainder;
  logic        ovf;
  logic        dbz;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  transposed_fir_hls_div_30s_14ns_16_seq dut (
    .ap_clk   (clk),
    .ap_rst   (ap_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division on magnitudes, then sign, rounding and clamping
  function automatic exp_t model(input logic [29:0] a, input logic [13:0] d);
    exp_t   e;
    longint sa, mag, qm, rm, sq;
    sa = longint'($signed(a));
    if (d == 0) begin
      e.q = (sa >= 0) ? 32767 : -32768;
      e.r = 0; e.ovf = 1'b1; e.dbz = 1'b1;
      return e;
    end
    mag = (sa < 0) ? -sa : sa;
    qm  = mag / longint'(d);
    rm  = mag % longint'(d);
`ifdef DIV_ROUND_NEAREST_EN
    if (2 * rm >= longint'(d)) qm = qm + 1;
`endif
    sq = (sa < 0) ? -qm : qm;
    e.ovf = 1'b0;
    if (sq > 32767) begin sq = 32767; e.ovf = 1'b1; end
    if (sq < -32768) begin sq = -32768; e.ovf = 1'b1; end
    e.q = sq;
    e.r = (sa < 0) ? -rm : rm;
    e.dbz = 1'b0;
    return e;
  endfunction

  // Checks every cycle a result is presented; pops on handshake
  always @(negedge clk) begin
    if (!ap_rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 0);
      end else begin
        chk("quotient", $signed(quotient), exp_q[0].q);
        chk("remainder", $signed(remainder), exp_q[0].r);
        chk("ovf", 64'(ovf), 64'(exp_q[0].ovf));
        chk("dbz", 64'(dbz), 64'(exp_q[0].dbz));
        chk("in_ready_while_valid", 64'(in_ready), 0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_div(input logic [29:0] a, input logic [13:0] d, input int hold);
    int guard;
    int c0;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 1);
      return;
    end
    in_valid = 1'b1; dividend = a; divisor = d;
    exp_q.push_back(model(a, d));
    @(posedge clk); #1;
    c0 = cyc;
    in_valid = 1'b0; dividend = 30'($urandom); divisor = 14'($urandom);
    guard = 0;
    while (!out_valid && guard < 60) begin @(posedge clk); #1; guard++; end
    chk("latency", 64'(cyc - c0 + 1), 31);
    if (!out_valid) begin
      exp_q.delete();
      return;
    end
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = 30'($urandom); divisor = 14'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_handshake", 64'(in_ready), 1);
    chk("out_valid_after_handshake", 64'(out_valid), 0);
  endtask

  initial begin
    exp_t e;
    logic [29:0] a;
    logic [13:0] d;
    ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_quotient", 64'(quotient), 0);
    chk("rst_remainder", 64'(remainder), 0);
    chk("rst_ovf", 64'(ovf), 0);
    chk("rst_dbz", 64'(dbz), 0);
    repeat (2) @(posedge clk);
    #1 ap_rst = 1'b0;

    // Hand-computed values pinning the model
    e = model(30'(-1000000), 14'd100);
    chk("pin1_q", e.q, -10000); chk("pin1_r", e.r, 0); chk("pin1_ovf", 64'(e.ovf), 0);
    e = model(30'(-7), 14'd2);
`ifdef DIV_ROUND_NEAREST_EN
    chk("pin2_q", e.q, -4);
`else
    chk("pin2_q", e.q, -3);
`endif
    chk("pin2_r", e.r, -1);
    e = model(30'd1000001, 14'd7);
    chk("pin3_q", e.q, 32767); chk("pin3_r", e.r, 2); chk("pin3_ovf", 64'(e.ovf), 1);
    e = model(30'h2000_0000, 14'd1);
    chk("pin3b_q", e.q, -32768); chk("pin3b_ovf", 64'(e.ovf), 1);
    e = model(30'd5, 14'd0);
    chk("pin4_q", e.q, 32767); chk("pin4_dbz", 64'(e.dbz), 1);
    e = model(30'(-5), 14'd0);
    chk("pin4b_q", e.q, -32768);

    // Directed vectors through the DUT
    do_div(30'(-1000000), 14'd100, 0);
    do_div(30'(-7), 14'd2, 1);
    do_div(30'd1000001, 14'd7, 0);
    do_div(30'h2000_0000, 14'd1, 0);
    do_div(30'd5, 14'd0, 0);
    do_div(30'(-5), 14'd0, 2);
    do_div(30'd0, 14'd9, 0);
    do_div(30'(-32768 * 3), 14'd3, 0);
    do_div(30'(32768 * 3), 14'd3, 0);
    do_div(30'd123456, 14'd16383, 5);

    // Reset mid-calculation discards the in-flight operation
    in_valid = 1'b1; dividend = 30'd999; divisor = 14'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 ap_rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_in_ready", 64'(in_ready), 1);
    chk("midrst_quotient", 64'(quotient), 0);
    @(posedge clk); #1 ap_rst = 1'b0;
    exp_q.delete();
    do_div(30'd100, 14'd3, 0);

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = 30'($urandom); d = 14'($urandom); end
        1: begin a = 30'(int'($urandom_range(0, 2097151)) - 1048576); d = 14'($urandom_range(1, 16383)); end
        2: begin a = 30'($urandom); d = 14'd0; end
        default: begin a = 30'(int'($urandom_range(0, 65535)) - 32768); d = 14'($urandom_range(1, 15)); end
      endcase
      do_div(a, d, int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
